matched_filter_sweep_ctrl: RTL and testbench

MATCHED_FILTER_SWEEP_CTRL -- requirements
Module: matched_filter_sweep_ctrl

---
 rtl/matched_filter_pkg.sv | 22 ++
 rtl/sweep_capture_ram.sv | 29 ++
 rtl/matched_filter_sweep_ctrl.sv | 142 ++++++++++++++
 tb/tb_matched_filter_sweep_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/matched_filter_pkg.sv
// Shared state encoding, default widths and index-width helper for the
// matched-filter sweep controller.
package matched_filter_pkg;

  localparam int MF_SAMPLE_DATA_WIDTH = 8;
  localparam int MF_CORR_WIDTH        = 32;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    STREAM,
    WAIT_RES,
    GAP,
    DONE
  } sweep_state_e;

  // Index width that never collapses to zero bits for a depth of one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sweep_capture_ram.sv
// Capture buffer: simple dual-port, one write port, one registered read port.
// The storage array is never reset; only the read register is.
module sweep_capture_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 1000,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/matched_filter_sweep_ctrl.sv
// Captures one block of samples, then replays it once per circular phase shift
// into a matched filter and tracks the strongest correlation.
// Optional: SWEEP_TIMEOUT_EN adds a result timeout and the timeout_err output.
module matched_filter_sweep_ctrl
  import matched_filter_pkg::*;
#(
  parameter int SAMPLE_DATA_WIDTH = MF_SAMPLE_DATA_WIDTH,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int NUM_SHIFTS        = 2000,
  parameter int CORR_WIDTH        = MF_CORR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0]         axiid,
  output logic                                 mf_axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0]         mf_axiod,
  input  logic                                 mf_res_valid,
  input  logic signed [CORR_WIDTH-1:0]         mf_res,
  output logic                                 busy,
  output logic                                 done,
  output logic signed [CORR_WIDTH-1:0]         peak_value,
  output logic [idx_width(NUM_SHIFTS)-1:0]     peak_shift
`ifdef SWEEP_TIMEOUT_EN
  ,
  output logic                                 timeout_err
`endif
);

  localparam int AW = idx_width(CAPTURE_LENGTH);
  localparam int SW = idx_width(NUM_SHIFTS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(CAPTURE_LENGTH - 1);
  localparam logic [SW-1:0] LAST_SHIFT = SW'(NUM_SHIFTS - 1);

  sweep_state_e state, state_nxt;
  logic [AW-1:0] wr_idx, beat, base, rd_idx;
  logic [AW:0]   rd_sum;
  logic [SW-1:0] shift;
  logic          have_peak, timeout_hit;

  assign busy = !(state == IDLE || state == DONE);
  assign done = (state == DONE);

  // base tracks shift mod CAPTURE_LENGTH, so base+beat wraps at most once.
  assign rd_sum = {1'b0, base} + {1'b0, beat};
  assign rd_idx = (rd_sum >= (AW+1)'(CAPTURE_LENGTH))
                ? AW'(rd_sum - (AW+1)'(CAPTURE_LENGTH)) : AW'(rd_sum);

  sweep_capture_ram #(.DW(SAMPLE_DATA_WIDTH), .DEPTH(CAPTURE_LENGTH), .AW(AW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (state == CAPTURE && axiiv),
    .waddr (wr_idx),
    .wdata (axiid),
    .re    (state == STREAM),
    .raddr (rd_idx),
    .rdata (mf_axiod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = CAPTURE;
      CAPTURE:    if (axiiv && wr_idx == LAST_IDX) state_nxt = STREAM;
      STREAM:     if (beat == LAST_IDX) state_nxt = WAIT_RES;
      WAIT_RES:   if (mf_res_valid || timeout_hit) state_nxt = GAP;
      GAP:        state_nxt = (shift == LAST_SHIFT) ? DONE : STREAM;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx     <= '0;
      beat       <= '0;
      base       <= '0;
      shift      <= '0;
      have_peak  <= 1'b0;
      peak_value <= '0;
      peak_shift <= '0;
      mf_axiov   <= 1'b0;
    end else begin
      // Read data lands one cycle after the address, so valid trails STREAM.
      mf_axiov <= (state == STREAM);
      case (state)
        IDLE, DONE: if (start) begin
          wr_idx    <= '0;
          have_peak <= 1'b0;
        end
        CAPTURE: if (axiiv) begin
          if (wr_idx == LAST_IDX) begin
            wr_idx <= '0;
            beat   <= '0;
            base   <= '0;
            shift  <= '0;
          end else begin
            wr_idx <= wr_idx + 1'b1;
          end
        end
        STREAM: beat <= (beat == LAST_IDX) ? '0 : beat + 1'b1;
        WAIT_RES: if (mf_res_valid && (!have_peak || mf_res > peak_value)) begin
          peak_value <= mf_res;
          peak_shift <= shift;
          have_peak  <= 1'b1;
        end
        GAP: if (shift != LAST_SHIFT) begin
          shift <= shift + 1'b1;
          base  <= (base == LAST_IDX) ? '0 : base + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SWEEP_TIMEOUT_EN
  localparam int TW = idx_width(4 * CAPTURE_LENGTH);
  logic [TW-1:0] wait_cnt;

  assign timeout_hit = (state == WAIT_RES) && !mf_res_valid
                    && (wait_cnt == TW'(4 * CAPTURE_LENGTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT_RES) ? wait_cnt + 1'b1 : '0;
      if ((state == IDLE || state == DONE) && start) timeout_err <= 1'b0;
      else if (timeout_hit)                          timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_matched_filter_sweep_ctrl.sv
// Self-checking bench: a per-cycle monitor compares replayed beats against the
// captured samples and plays the matched filter; sweep results are scored by a
// plain max-search over the returned correlations.
module tb_matched_filter_sweep_ctrl;

  localparam int L  = 8;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int SW = 2;
  localparam logic signed [CW-1:0] BIG = 32'sh3fff_ffff;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, axiiv = 1'b0, mf_res_valid = 1'b0;
  logic [DW-1:0] axiid = '0;
  logic signed [CW-1:0] mf_res = '0;
  logic mf_axiov, busy, done;
  logic [DW-1:0] mf_axiod;
  logic signed [CW-1:0] peak_value;
  logic [SW-1:0] peak_shift;
`ifdef SWEEP_TIMEOUT_EN
  logic timeout_err;
`endif

  int errors = 0, checks = 0;
  int cap [L];
  int res [N];
  int dly [N];
  int pass2 [L];
  int pass_i = 0, beat_i = 0, run = 0, rv_wait = -1;

  always #5 clk = ~clk;

  matched_filter_sweep_ctrl #(
    .SAMPLE_DATA_WIDTH(DW), .CAPTURE_LENGTH(L), .NUM_SHIFTS(N), .CORR_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .axiiv        (axiiv),
    .axiid        (axiid),
    .mf_axiov     (mf_axiov),
    .mf_axiod     (mf_axiod),
    .mf_res_valid (mf_res_valid),
    .mf_res       (mf_res),
    .busy         (busy),
    .done         (done),
    .peak_value   (peak_value),
    .peak_shift   (peak_shift)
`ifdef SWEEP_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare at the falling edge; also drives the filter result.
  task automatic monitor();
    if (!rst) begin
      pass_i = 0; beat_i = 0; run = 0; rv_wait = -1;
      mf_res_valid = 1'b0; mf_res = '0;
      return;
    end
    mf_res_valid = 1'b0;
    if (start && !busy) begin
      pass_i = 0; beat_i = 0; run = 0; rv_wait = -1;
    end
    if (mf_axiov) begin
      chk("busy_during_beat", busy, 1);
      chk("pass_in_range", pass_i < N, 1);
      chk("beat_data", mf_axiod, cap[(pass_i + beat_i) % L]);
      if (pass_i == 2) pass2[beat_i] = int'(mf_axiod);
      beat_i++; run++;
      if (beat_i == L) begin
        rv_wait = (pass_i < N) ? dly[pass_i] : -1;
        beat_i = 0; pass_i++;
      end else if (beat_i <= L - 2 && $urandom_range(0, 3) == 0) begin
        mf_res_valid = 1'b1; mf_res = BIG;
      end
    end else begin
      if (run != 0) begin chk("run_length", run, L); run = 0; end
      if (!busy && $urandom_range(0, 3) == 0) begin mf_res_valid = 1'b1; mf_res = BIG; end
    end
    if (rv_wait == 0) begin
      mf_res_valid = 1'b1; mf_res = res[pass_i - 1]; rv_wait = -1;
    end else if (rv_wait > 0) begin
      rv_wait--;
    end
  endtask

  task automatic cycle();
    @(negedge clk); monitor();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mf_axiov", mf_axiov, 0);
    chk("rst_mf_axiod", mf_axiod, 0);
    chk("rst_peak_value", peak_value, 0);
    chk("rst_peak_shift", peak_shift, 0);
  endtask

  task automatic capture(input bit gaps, input bit incr);
    int n = 0;
    bit skip = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    while (n < L) begin
      if (gaps && skip) begin
        axiiv = 1'b0; axiid = DW'($urandom);
      end else begin
        axiiv = 1'b1; axiid = incr ? DW'(n + 1) : DW'($urandom);
        cap[n] = int'(axiid); n++;
      end
      skip = gaps ? !skip : 1'b0;
      cycle();
    end
    axiiv = 1'b0;
  endtask

  task automatic wait_done(input bit poke_start);
    int cyc = 0;
    bit poked = 1'b0;
    while (!done && cyc < 2000) begin
      axiiv = ($urandom_range(0, 1) == 1); axiid = DW'($urandom);
      start = poke_start && !poked && pass_i == 1 && beat_i == 2;
      if (start) poked = 1'b1;
      cycle(); cyc++;
      start = 1'b0;
    end
    axiiv = 1'b0;
    chk("done_reached", done, 1);
  endtask

  task automatic check_result();
    int pk = 0, ps = 0;
    bit have = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
    bit to = 1'b0;
    for (int s = 0; s < N; s++) if (dly[s] < 0) to = 1'b1;
    chk("timeout_err", timeout_err, to);
`endif
    for (int s = 0; s < N; s++)
      if (dly[s] >= 0 && (!have || res[s] > pk)) begin pk = res[s]; ps = s; have = 1'b1; end
    chk("busy_in_done", busy, 0);
    chk("passes_seen", pass_i, N);
    chk("peak_value", peak_value, pk);
    chk("peak_shift", peak_shift, ps);
    repeat (4) cycle();
    chk("done_held", done, 1);
    chk("peak_value_held", peak_value, pk);
    chk("peak_shift_held", peak_shift, ps);
  endtask

  initial begin
    int exp2 [L] = '{3, 4, 5, 6, 7, 8, 1, 2};
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b1;
    repeat (2) cycle();

    // Incrementing samples, known results
    res = '{5, -3, 9, 9}; dly = '{0, 0, 0, 0};
    capture(1'b0, 1'b1); wait_done(1'b0); check_result();
    for (int k = 0; k < L; k++) chk("pass2_beat_lit", pass2[k], exp2[k]);
    chk("peak_value_lit", peak_value, 9);
    chk("peak_shift_lit", peak_shift, 2);

    // Alternating axiiv during capture
    res = '{1, 2, 3, 4}; dly = '{1, 0, 2, 3};
    capture(1'b1, 1'b0); wait_done(1'b0); check_result();

    // All-equal negative results, start poked while busy
    res = '{-7, -7, -7, -7}; dly = '{0, 2, 1, 0};
    capture(1'b0, 1'b0); wait_done(1'b1); check_result();
    chk("neg_peak_value_lit", peak_value, -7);
    chk("neg_peak_shift_lit", peak_shift, 0);

    // Reset during pass 1 replay, then a clean sweep
    res = '{5, -3, 9, 9}; dly = '{0, 0, 0, 0};
    capture(1'b0, 1'b1);
    cyc = 0;
    while (!(pass_i == 1 && beat_i == 3) && cyc < 500) begin cycle(); cyc++; end
    chk("reached_pass1", (pass_i == 1 && beat_i == 3), 1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs();
    cycle(); cycle();
    rst = 1'b1;
    repeat (3) cycle();
    chk("idle_after_reset_busy", busy, 0);
    chk("idle_after_reset_done", done, 0);
    capture(1'b0, 1'b1); wait_done(1'b0); check_result();
    chk("rerun_peak_value_lit", peak_value, 9);
    chk("rerun_peak_shift_lit", peak_shift, 2);

`ifdef SWEEP_TIMEOUT_EN
    // Result withheld for pass 1
    res = '{4, 100, 6, 2}; dly = '{0, -1, 1, 0};
    capture(1'b0, 1'b0); wait_done(1'b0); check_result();
    chk("timeout_peak_value_lit", peak_value, 6);
    chk("timeout_peak_shift_lit", peak_shift, 2);
`endif

    // Randomised sweeps
    repeat (6) begin
      for (int s = 0; s < N; s++) begin
        res[s] = int'($urandom_range(0, 60)) - 30;
        dly[s] = int'($urandom_range(0, 3));
      end
      capture(1'($urandom_range(0, 1)), 1'b0);
      wait_done(1'($urandom_range(0, 1)));
      check_result();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
